// File: rtl/gb_cpu_common_pkg.sv
// rtl/gb_cpu_common_pkg.sv - shared CPU-side types and memory map constants
package gb_cpu_common_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_DELAY = 2'd1,
        DMA_XFER  = 2'd2
    } dma_state_t;

    localparam logic [15:0] ADDR_DMA_REG  = 16'hFF46;
    localparam logic [15:0] ADDR_OAM_BASE = 16'hFE00;
    localparam logic [15:0] ADDR_OAM_END  = 16'hFE9F;
    localparam logic [15:0] ADDR_IO_BASE  = 16'hFF00;
    localparam int          OAM_LEN       = 160;

    // Sources at E0-FF alias work RAM through the echo region.
    function automatic logic [7:0] dma_src_fold(input logic [7:0] reg_val);
        return (reg_val >= 8'hE0) ? reg_val - 8'h20 : reg_val;
    endfunction

endpackage

// File: rtl/gb_oam_dma_arbiter_if.sv
// rtl/gb_oam_dma_arbiter_if.sv - CPU, main bus and OAM signals of the DMA arbiter
interface gb_oam_dma_arbiter_if;
    logic [15:0] cpu_addr_i;
    logic [7:0]  cpu_data_i;
    logic        cpu_drive_i;
    logic [7:0]  cpu_data_o;
    logic        cpu_blocked_o;
    logic [15:0] bus_addr_o;
    logic [7:0]  bus_data_o;
    logic        bus_we_o;
    logic [7:0]  bus_data_i;
    logic [7:0]  oam_addr_o;
    logic [7:0]  oam_data_o;
    logic        oam_we_o;
    logic [7:0]  oam_data_i;
    logic        dma_active_o;
    logic [7:0]  dma_reg_o;

    modport slave (
        input  cpu_addr_i, cpu_data_i, cpu_drive_i, bus_data_i, oam_data_i,
        output cpu_data_o, cpu_blocked_o, bus_addr_o, bus_data_o, bus_we_o,
               oam_addr_o, oam_data_o, oam_we_o, dma_active_o, dma_reg_o
    );

    modport master (
        output cpu_addr_i, cpu_data_i, cpu_drive_i, bus_data_i, oam_data_i,
        input  cpu_data_o, cpu_blocked_o, bus_addr_o, bus_data_o, bus_we_o,
               oam_addr_o, oam_data_o, oam_we_o, dma_active_o, dma_reg_o
    );
endinterface

// File: rtl/gb_oam_dma_engine.sv
// rtl/gb_oam_dma_engine.sv - OAM DMA sequencer: FSM, byte index, source register and echo fold
module gb_oam_dma_engine
    import gb_cpu_common_pkg::*;
#(
    parameter int XFER_LEN = OAM_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trig_i,
    input  logic [7:0] trig_data_i,
    output dma_state_t state_o,
    output logic [7:0] index_o,
    output logic [7:0] src_o,
    output logic [7:0] dma_reg_o,
    output logic       active_o
);

    localparam logic [7:0] LAST_INDEX = 8'(XFER_LEN - 1);

    dma_state_t state_q;
    logic [7:0] index_q;
    logic [7:0] dma_reg_q;
    logic       restart_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= DMA_IDLE;
            index_q   <= 8'd0;
            dma_reg_q <= 8'hFF;
            restart_q <= 1'b0;
        end else if (trig_i) begin
            // A new trigger always wins; restart keeps the CPU locked out through DELAY.
            dma_reg_q <= trig_data_i;
            state_q   <= DMA_DELAY;
            index_q   <= 8'd0;
            restart_q <= (state_q == DMA_XFER) || ((state_q == DMA_DELAY) && restart_q);
        end else begin
            case (state_q)
                DMA_DELAY: begin
                    state_q   <= DMA_XFER;
                    index_q   <= 8'd0;
                    restart_q <= 1'b0;
                end
                DMA_XFER: begin
                    if (index_q == LAST_INDEX) begin
                        state_q <= DMA_IDLE;
                        index_q <= 8'd0;
                    end else begin
                        index_q <= index_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= DMA_IDLE;
                end
            endcase
        end
    end

    assign state_o   = state_q;
    assign index_o   = index_q;
    assign dma_reg_o = dma_reg_q;
    assign src_o     = dma_src_fold(dma_reg_q);
    assign active_o  = (state_q == DMA_XFER) || ((state_q == DMA_DELAY) && restart_q);

endmodule

// File: rtl/gb_oam_dma_arbiter.sv
// rtl/gb_oam_dma_arbiter.sv - main bus / OAM owner arbitrating CPU accesses against OAM DMA
module gb_oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR = gb_cpu_common_pkg::ADDR_DMA_REG,
    parameter int          OAM_LEN      = gb_cpu_common_pkg::OAM_LEN,
    parameter logic [15:0] OAM_BASE     = gb_cpu_common_pkg::ADDR_OAM_BASE
) (
    input  logic                clk,
    input  logic                reset,
    gb_oam_dma_arbiter_if.slave ifc
);

    localparam logic [15:0] OAM_END = OAM_BASE + 16'(OAM_LEN) - 16'd1;
    localparam logic [15:0] IO_BASE = gb_cpu_common_pkg::ADDR_IO_BASE;

    gb_cpu_common_pkg::dma_state_t state;
    logic [7:0] index;
    logic [7:0] src;
    logic [7:0] dma_reg;
    logic       active;
    logic       trig;

    assign trig = ifc.cpu_drive_i && (ifc.cpu_addr_i == DMA_REG_ADDR);

    gb_oam_dma_engine #(
        .XFER_LEN (OAM_LEN)
    ) u_engine (
        .clk         (clk),
        .reset       (reset),
        .trig_i      (trig),
        .trig_data_i (ifc.cpu_data_i),
        .state_o     (state),
        .index_o     (index),
        .src_o       (src),
        .dma_reg_o   (dma_reg),
        .active_o    (active)
    );

    logic [7:0]  cpu_data;
    logic        blocked;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data;
    logic        bus_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        oam_we;

    always_comb begin
        cpu_data = 8'hFF;
        blocked  = active && (ifc.cpu_addr_i < IO_BASE);
        bus_addr = 16'h0000;
        bus_data = 8'h00;
        bus_we   = 1'b0;
        oam_addr = 8'h00;
        oam_data = 8'h00;
        oam_we   = 1'b0;

        if (state == gb_cpu_common_pkg::DMA_XFER) begin
            bus_addr = {src, index};
            oam_addr = index;
            oam_data = ifc.bus_data_i;
            oam_we   = 1'b1;
        end

        // XFER always implies blocked for sub-IO addresses, so the two drivers never overlap.
        if (!blocked) begin
            if (ifc.cpu_addr_i < OAM_BASE) begin
                bus_addr = ifc.cpu_addr_i;
                bus_data = ifc.cpu_data_i;
                bus_we   = ifc.cpu_drive_i;
                cpu_data = ifc.bus_data_i;
            end else if (ifc.cpu_addr_i <= OAM_END) begin
                oam_addr = ifc.cpu_addr_i[7:0];
                oam_data = ifc.cpu_data_i;
                oam_we   = ifc.cpu_drive_i;
                cpu_data = ifc.oam_data_i;
            end else if (ifc.cpu_addr_i < IO_BASE) begin
                cpu_data = 8'h00;
            end
        end
    end

    assign ifc.cpu_data_o    = cpu_data;
    assign ifc.cpu_blocked_o = blocked;
    assign ifc.bus_addr_o    = bus_addr;
    assign ifc.bus_data_o    = bus_data;
    assign ifc.bus_we_o      = bus_we;
    assign ifc.oam_addr_o    = oam_addr;
    assign ifc.oam_data_o    = oam_data;
    assign ifc.oam_we_o      = oam_we;
    assign ifc.dma_active_o  = active;
    assign ifc.dma_reg_o     = dma_reg;

endmodule

// File: tb/tb_gb_oam_dma_arbiter.sv
// tb/tb_gb_oam_dma_arbiter.sv - self-checking bench for gb_oam_dma_arbiter
module tb_gb_oam_dma_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    gb_oam_dma_arbiter_if ifc ();

    gb_oam_dma_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .ifc   (ifc)
    );

    typedef struct packed {
        logic [7:0]  cpu_data;
        logic        blocked;
        logic [15:0] bus_addr;
        logic [7:0]  bus_data;
        logic        bus_we;
        logic [7:0]  oam_addr;
        logic [7:0]  oam_data;
        logic        oam_we;
        logic        active;
        logic [7:0]  dma_reg;
    } obs_t;

    int n_checks = 0;
    int n_errors = 0;

    // Model: cycles elapsed since the last accepted trigger (0 = no copy pending).
    int         m_since;
    logic [7:0] m_reg;
    bit         m_restart;

    obs_t got;
    obs_t exp;

    function automatic obs_t sample();
        obs_t s;
        s.cpu_data = ifc.cpu_data_o;
        s.blocked  = ifc.cpu_blocked_o;
        s.bus_addr = ifc.bus_addr_o;
        s.bus_data = ifc.bus_data_o;
        s.bus_we   = ifc.bus_we_o;
        s.oam_addr = ifc.oam_addr_o;
        s.oam_data = ifc.oam_data_o;
        s.oam_we   = ifc.oam_we_o;
        s.active   = ifc.dma_active_o;
        s.dma_reg  = ifc.dma_reg_o;
        return s;
    endfunction

    function automatic bit model_active();
        return (m_since >= 2) || (m_since == 1 && m_restart);
    endfunction

    function automatic obs_t model_out();
        obs_t e;
        logic [15:0] a;
        logic [7:0] src;
        a = ifc.cpu_addr_i;
        e = '0;
        e.cpu_data = 8'hFF;
        e.dma_reg  = m_reg;
        e.active   = model_active();
        e.blocked  = e.active && (a < 16'hFF00);
        if (m_since >= 2) begin
            src = (m_reg >= 8'hE0) ? m_reg - 8'h20 : m_reg;
            e.bus_addr = {src, 8'(m_since - 2)};
            e.oam_addr = 8'(m_since - 2);
            e.oam_data = ifc.bus_data_i;
            e.oam_we   = 1'b1;
        end
        if (!e.blocked) begin
            if (a <= 16'hFDFF) begin
                e.bus_addr = a;
                e.bus_data = ifc.cpu_data_i;
                e.bus_we   = ifc.cpu_drive_i;
                e.cpu_data = ifc.bus_data_i;
            end else if (a <= 16'hFE9F) begin
                e.oam_addr = a[7:0];
                e.oam_data = ifc.cpu_data_i;
                e.oam_we   = ifc.cpu_drive_i;
                e.cpu_data = ifc.oam_data_i;
            end else if (a <= 16'hFEFF) begin
                e.cpu_data = 8'h00;
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        m_since   = 0;
        m_reg     = 8'hFF;
        m_restart = 1'b0;
    endtask

    task automatic model_step();
        if (ifc.cpu_drive_i && ifc.cpu_addr_i == 16'hFF46) begin
            m_restart = model_active();
            m_since   = 1;
            m_reg     = ifc.cpu_data_i;
        end else if (m_since > 0) begin
            m_since++;
            if (m_since > 161) m_since = 0;
        end
    endtask

    task automatic apply(input logic [15:0] a, input logic [7:0] d, input logic w);
        ifc.cpu_addr_i  = a;
        ifc.cpu_data_i  = d;
        ifc.cpu_drive_i = w;
        ifc.bus_data_i  = 8'($urandom);
        ifc.oam_data_i  = 8'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        case ($urandom_range(0, 3))
            0:       a = 16'($urandom_range(0, 16'hFDFF));
            1:       a = 16'($urandom_range(16'hFE00, 16'hFEFF));
            2:       a = 16'($urandom_range(16'hFF00, 16'hFFFF));
            default: a = 16'($urandom);
        endcase
        if (a == 16'hFF46) a = 16'hFF47;
        return a;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        apply(16'hFFFF, 8'h00, 1'b0);
        #12;
        exp = '0;
        exp.cpu_data = 8'hFF;
        exp.dma_reg  = 8'hFF;
        got = sample();
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL reset_state got %h expected %h", got, exp);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_copy();
        apply(16'hFF46, 8'hC1, 1'b1);
        @(negedge clk);
        got = sample(); exp = model_out(); n_checks++;
        if (got !== exp) begin n_errors++; $display("FAIL copy_trigger got %h expected %h", got, exp); end
        tick();
        apply(rand_addr(), 8'($urandom), 1'($urandom));
        @(negedge clk);
        n_checks++;
        if (ifc.dma_active_o !== 1'b0 || ifc.oam_we_o !== (ifc.cpu_drive_i && ifc.cpu_addr_i >= 16'hFE00 && ifc.cpu_addr_i <= 16'hFE9F)) begin
            n_errors++;
            $display("FAIL copy_delay active=%b oam_we=%b required active=0 and no dma write", ifc.dma_active_o, ifc.oam_we_o);
        end
        got = sample(); exp = model_out(); n_checks++;
        if (got !== exp) begin n_errors++; $display("FAIL copy_delay_model got %h expected %h", got, exp); end
        tick();
        for (int i = 0; i < 160; i++) begin
            apply(rand_addr(), 8'($urandom), 1'($urandom));
            @(negedge clk);
            n_checks++;
            if (ifc.bus_addr_o !== 16'hC100 + 16'(i) || ifc.oam_addr_o !== 8'(i) || ifc.oam_we_o !== 1'b1 || ifc.oam_data_o !== ifc.bus_data_i) begin
                n_errors++;
                $display("FAIL copy_xfer idx %0d bus_addr=%h oam_addr=%h oam_we=%b required %h %h 1", i, ifc.bus_addr_o, ifc.oam_addr_o, ifc.oam_we_o, 16'hC100 + 16'(i), 8'(i));
            end
            got = sample(); exp = model_out(); n_checks++;
            if (got !== exp) begin n_errors++; $display("FAIL copy_xfer_model idx %0d got %h expected %h", i, got, exp); end
            tick();
        end
        apply(16'hC000, 8'h77, 1'b1);
        @(negedge clk);
        n_checks++;
        if (ifc.dma_active_o !== 1'b0 || ifc.cpu_blocked_o !== 1'b0 || ifc.bus_we_o !== 1'b1 || ifc.bus_addr_o !== 16'hC000 || ifc.bus_data_o !== 8'h77) begin
            n_errors++;
            $display("FAIL copy_done active=%b blocked=%b we=%b addr=%h required 0 0 1 C000", ifc.dma_active_o, ifc.cpu_blocked_o, ifc.bus_we_o, ifc.bus_addr_o);
        end
        tick();
    endtask

    task automatic test_blocking();
        apply(16'hFF46, 8'h12, 1'b1);
        @(negedge clk); tick();
        apply(16'hFFFF, 8'h00, 1'b0);
        @(negedge clk); tick();
        apply(16'h8000, 8'h00, 1'b0);
        @(negedge clk);
        n_checks++;
        if (ifc.cpu_data_o !== 8'hFF || ifc.cpu_blocked_o !== 1'b1) begin
            n_errors++;
            $display("FAIL block_read data=%h blocked=%b required FF 1", ifc.cpu_data_o, ifc.cpu_blocked_o);
        end
        tick();
        apply(16'hC000, 8'h55, 1'b1);
        @(negedge clk);
        n_checks++;
        if (ifc.bus_we_o !== 1'b0 || ifc.cpu_blocked_o !== 1'b1 || ifc.bus_addr_o !== 16'h1201 || ifc.oam_addr_o !== 8'h01) begin
            n_errors++;
            $display("FAIL block_write we=%b blocked=%b bus_addr=%h oam_addr=%h required 0 1 1201 01", ifc.bus_we_o, ifc.cpu_blocked_o, ifc.bus_addr_o, ifc.oam_addr_o);
        end
        tick();
        apply(16'hFF85, 8'h00, 1'b0);
        @(negedge clk);
        n_checks++;
        if (ifc.cpu_data_o !== 8'hFF || ifc.cpu_blocked_o !== 1'b0) begin
            n_errors++;
            $display("FAIL block_hram data=%h blocked=%b required FF 0", ifc.cpu_data_o, ifc.cpu_blocked_o);
        end
        tick();
        for (int i = 3; i < 161; i++) begin
            apply(rand_addr(), 8'($urandom), 1'($urandom));
            @(negedge clk);
            got = sample(); exp = model_out(); n_checks++;
            if (got !== exp) begin n_errors++; $display("FAIL block_tail_model cyc %0d got %h expected %h", i, got, exp); end
            tick();
        end
    endtask

    task automatic test_echo_fold();
        apply(16'hFF46, 8'hF3, 1'b1);
        @(negedge clk); tick();
        apply(16'hFFFF, 8'h00, 1'b0);
        @(negedge clk); tick();
        for (int i = 0; i < 160; i++) begin
            apply(rand_addr(), 8'($urandom), 1'($urandom));
            @(negedge clk);
            n_checks++;
            if (ifc.bus_addr_o !== 16'hD300 + 16'(i)) begin
                n_errors++;
                $display("FAIL echo_fold idx %0d bus_addr=%h required %h", i, ifc.bus_addr_o, 16'hD300 + 16'(i));
            end
            got = sample(); exp = model_out(); n_checks++;
            if (got !== exp) begin n_errors++; $display("FAIL echo_model idx %0d got %h expected %h", i, got, exp); end
            tick();
        end
    endtask

    task automatic test_restart();
        apply(16'hFF46, 8'h45, 1'b1);
        @(negedge clk); tick();
        apply(16'hFFFF, 8'h00, 1'b0);
        @(negedge clk); tick();
        for (int i = 0; i <= 50; i++) begin
            if (i == 50) apply(16'hFF46, 8'h80, 1'b1);
            else         apply(rand_addr(), 8'($urandom), 1'($urandom));
            @(negedge clk);
            got = sample(); exp = model_out(); n_checks++;
            if (got !== exp) begin n_errors++; $display("FAIL restart_pre_model idx %0d got %h expected %h", i, got, exp); end
            tick();
        end
        apply(16'h9000, 8'h00, 1'b0);
        @(negedge clk);
        n_checks++;
        if (ifc.dma_active_o !== 1'b1 || ifc.oam_we_o !== 1'b0 || ifc.cpu_blocked_o !== 1'b1 || ifc.dma_reg_o !== 8'h80) begin
            n_errors++;
            $display("FAIL restart_delay active=%b oam_we=%b blocked=%b reg=%h required 1 0 1 80", ifc.dma_active_o, ifc.oam_we_o, ifc.cpu_blocked_o, ifc.dma_reg_o);
        end
        tick();
        for (int i = 0; i < 160; i++) begin
            apply(rand_addr(), 8'($urandom), 1'($urandom));
            @(negedge clk);
            if (i == 0) begin
                n_checks++;
                if (ifc.oam_addr_o !== 8'h00 || ifc.bus_addr_o !== 16'h8000 || ifc.oam_we_o !== 1'b1) begin
                    n_errors++;
                    $display("FAIL restart_first oam_addr=%h bus_addr=%h oam_we=%b required 00 8000 1", ifc.oam_addr_o, ifc.bus_addr_o, ifc.oam_we_o);
                end
            end
            got = sample(); exp = model_out(); n_checks++;
            if (got !== exp) begin n_errors++; $display("FAIL restart_post_model idx %0d got %h expected %h", i, got, exp); end
            tick();
        end
    endtask

    task automatic test_oam_passthrough();
        logic [15:0] addrs [6];
        logic [7:0]  datas [6];
        logic        wes   [6];
        addrs = '{16'hFE10, 16'hFEA5, 16'hFE9F, 16'hFEA0, 16'hFDFF, 16'hFF00};
        datas = '{8'h5A,    8'h00,    8'h00,    8'h33,    8'h00,    8'h00};
        wes   = '{1'b1,     1'b0,     1'b0,     1'b1,     1'b0,     1'b0};
        for (int i = 0; i < 6; i++) begin
            apply(addrs[i], datas[i], wes[i]);
            @(negedge clk);
            if (i == 0) begin
                n_checks++;
                if (ifc.oam_we_o !== 1'b1 || ifc.oam_addr_o !== 8'h10 || ifc.oam_data_o !== 8'h5A || ifc.bus_we_o !== 1'b0) begin
                    n_errors++;
                    $display("FAIL oam_write we=%b addr=%h data=%h required 1 10 5A", ifc.oam_we_o, ifc.oam_addr_o, ifc.oam_data_o);
                end
            end
            if (i == 1) begin
                n_checks++;
                if (ifc.cpu_data_o !== 8'h00) begin
                    n_errors++;
                    $display("FAIL unusable_read data=%h required 00", ifc.cpu_data_o);
                end
            end
            got = sample(); exp = model_out(); n_checks++;
            if (got !== exp) begin n_errors++; $display("FAIL passthrough_model addr %h got %h expected %h", addrs[i], got, exp); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        apply(16'hFF46, 8'h3C, 1'b1);
        @(negedge clk); tick();
        for (int i = 0; i < 21; i++) begin
            apply(rand_addr(), 8'($urandom), 1'($urandom));
            @(negedge clk);
            got = sample(); exp = model_out(); n_checks++;
            if (got !== exp) begin n_errors++; $display("FAIL areset_pre_model cyc %0d got %h expected %h", i, got, exp); end
            tick();
        end
        apply(16'hFF85, 8'h00, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (ifc.dma_active_o !== 1'b0 || ifc.oam_we_o !== 1'b0 || ifc.dma_reg_o !== 8'hFF || ifc.bus_addr_o !== 16'h0000) begin
            n_errors++;
            $display("FAIL async_reset active=%b oam_we=%b reg=%h bus_addr=%h required 0 0 FF 0000", ifc.dma_active_o, ifc.oam_we_o, ifc.dma_reg_o, ifc.bus_addr_o);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            apply(rand_addr(), 8'($urandom), 1'($urandom));
            @(negedge clk);
            n_checks++;
            if (ifc.dma_active_o !== 1'b0) begin
                n_errors++;
                $display("FAIL areset_idle cyc %0d active=%b required 0", i, ifc.dma_active_o);
            end
            got = sample(); exp = model_out(); n_checks++;
            if (got !== exp) begin n_errors++; $display("FAIL areset_post_model cyc %0d got %h expected %h", i, got, exp); end
            tick();
        end
    endtask

    task automatic test_random_traffic();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 39) == 0) apply(16'hFF46, 8'($urandom), 1'b1);
            else                            apply(rand_addr(), 8'($urandom), 1'($urandom));
            @(negedge clk);
            got = sample(); exp = model_out(); n_checks++;
            if (got !== exp) begin n_errors++; $display("FAIL random_model cyc %0d got %h expected %h", i, got, exp); end
            tick();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_copy();
        test_blocking();
        test_echo_fold();
        test_restart();
        test_oam_passthrough();
        test_async_reset();
        test_random_traffic();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gb_oam_dma_arbiter.md
Name: gb_oam_dma_arbiter

Overview:
- Owns the main memory bus (0x0000–0xFEFF) and the OAM port. Arbitrates between the CPU and an OAM DMA engine.
- Snoops CPU writes to the DMA register (0xFF46) and copies 160 bytes from {src,8'h00} into OAM, one byte per M-cycle.
- While DMA is active, CPU main-bus accesses are blocked. CPU traffic to 0xFF00–0xFFFF never enters this block; top level routes it separately.

Parameters:
- DMA_REG_ADDR, 16'hFF46, CPU address of the DMA source register.
- OAM_LEN, 160, number of bytes per transfer.
- OAM_BASE, 16'hFE00, first OAM address on the CPU map.

Ports:
- clk  in  1  machine (M) clock
- reset  in  1  asynchronous, active-low reset
- cpu_addr_i  in  16  CPU address bus
- cpu_data_i  in  8  CPU write data
- cpu_drive_i  in  1  CPU write enable for this cycle
- cpu_data_o  out  8  read data returned to CPU
- cpu_blocked_o  out  1  CPU main-bus access suppressed this cycle
- bus_addr_o  out  16  main bus address
- bus_data_o  out  8  main bus write data
- bus_we_o  out  1  main bus write enable
- bus_data_i  in  8  main bus read data, valid in the same cycle
- oam_addr_o  out  8  OAM index
- oam_data_o  out  8  OAM write data
- oam_we_o  out  1  OAM write enable
- oam_data_i  in  8  OAM read data, same cycle
- dma_active_o  out  1  transfer in progress
- dma_reg_o  out  8  current DMA register value, so the top level can return it on FF46 reads

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, index = 0, dma_reg = 8'hFF, restart flag = 0.
  - All outputs 0, except cpu_data_o = 8'hFF and dma_reg_o = 8'hFF.
- DMA trigger: cpu_drive_i && cpu_addr_i == DMA_REG_ADDR in cycle N.
  - dma_reg latches cpu_data_i at the end of cycle N.
  - The trigger is accepted in every state.
- States:
  - IDLE: CPU owns the bus.
  - DELAY: exactly one M-cycle (N+1). No DMA bus access.
    - Blocks the CPU only if entered from XFER (restart flag).
    - Next state is XFER with index = 0.
  - XFER: index runs 0..OAM_LEN-1, one per cycle (N+2..N+161). When index == OAM_LEN-1, next state is IDLE, so the CPU owns the bus again in N+162.
- Source address:
  - src = dma_reg.
  - If dma_reg >= 8'hE0, src = dma_reg - 8'h20 (echo-RAM fold).
- XFER cycle outputs:
  - bus_addr_o = {src, index}, bus_we_o = 0
  - oam_addr_o = index, oam_data_o = bus_data_i, oam_we_o = 1
- Restart: a trigger during XFER or DELAY aborts the current copy. Next cycle is DELAY with the new dma_reg, and dma_active_o stays high throughout.
- dma_active_o = XFER, or DELAY with the restart flag set.
- CPU routing when not blocked (addresses below 0xFF00):
  - 0x0000–0xFDFF: bus_addr_o = cpu_addr_i, bus_data_o = cpu_data_i, bus_we_o = cpu_drive_i, cpu_data_o = bus_data_i.
  - 0xFE00–0xFE9F: oam_addr_o = cpu_addr_i[7:0], oam_data_o = cpu_data_i, oam_we_o = cpu_drive_i, cpu_data_o = oam_data_i.
  - 0xFEA0–0xFEFF: cpu_data_o = 8'h00, writes dropped.
  - 0xFF00 and above: no bus or OAM activity, cpu_data_o = 8'hFF.
- Blocking, when dma_active_o is high and cpu_addr_i < 16'hFF00:
  - cpu_blocked_o = 1, cpu_data_o = 8'hFF.
  - CPU writes are dropped (no bus_we_o, no oam_we_o).
- The trigger write itself (0xFF46) is never blocked.
- Everything is combinational from state and inputs except the state, index, dma_reg and restart flag registers.
- Reset mid-transfer: immediate return to IDLE. OAM keeps whatever was already written.

Decomposition:
- Shared package gb_cpu_common_pkg gains:
  - dma_state_t enum (DMA_IDLE, DMA_DELAY, DMA_XFER)
  - constants ADDR_DMA_REG, ADDR_OAM_BASE, ADDR_OAM_END (16'hFE9F), ADDR_IO_BASE (16'hFF00), OAM_LEN
- One sub-module, gb_oam_dma_engine: the FSM, index counter, dma_reg and source fold.
- The top level keeps only the combinational address decode and the bus/OAM muxing.

Test Plan:
- Basic copy: after reset, CPU writes 8'hC1 to FF46 in cycle 0.
  - Cycle 1: dma_active_o = 0, no OAM writes.
  - Cycles 2..161: bus_addr_o = C100..C19F, oam_we_o = 1, oam_addr_o = 0..159, oam_data_o mirrors bus_data_i.
  - Cycle 162: IDLE, CPU owns the bus.
- Blocking: during XFER, CPU reads 0x8000 and writes 0xC000.
  - cpu_data_o = FF, cpu_blocked_o = 1, bus_we_o = 0.
  - A CPU read of 0xFF85 returns FF with cpu_blocked_o = 0.
- Echo fold: a trigger with 8'hF3 produces source addresses D300..D39F.
- Restart: at index 50, CPU writes 8'h80 to FF46.
  - Next cycle is DELAY with dma_active_o = 1.
  - Then oam_addr_o restarts at 0 with bus_addr_o = 8000.
- OAM passthrough when idle:
  - CPU write of 8'h5A to FE10 gives oam_we_o = 1, oam_addr_o = 8'h10.
  - A read of FEA5 returns 8'h00.
- Async reset: reset low mid-XFER, with no clock edge.
  - Outputs drop immediately: dma_active_o = 0, oam_we_o = 0, dma_reg_o = FF.
  - After release the block stays IDLE until the next FF46 write.
